hub75_bcm_scan_gen: RTL
=======================

// Module: hub75_bcm_scan_gen
// PURPOSE
//  Parametrised HUB75 scan/BCM timing generator for chained LED panels. Sequences bit planes MSB->LSB,
//  rows 0..NUM_ROWS-1 per plane, reading pixel RAM and shifting data while the previous row is lit.
//  Adds shadowed per-frame config, a binary-weighted on-time (base << k), an anti-ghost blanking guard,
//  a synchronous led_clk enable (no gated clock) and a frame-buffer swap handshake.
//  Sits between the AXI config regs / frame-buffer RAM and the HUB75 output pins.
// PARAMETERS
//  NUM_ROWS      32  scan rows per plane (row_addr 0..NUM_ROWS-1)
//  ROW_W         5   row address width, clog2(NUM_ROWS)
//  X_W           10  pixel-in-row address width
//  NUM_PLANES    8   bit planes stored; plane index 0..NUM_PLANES-1
//  MIN_PLANE     2   lowest plane displayed; planes below are skipped
//  RAM_LAT       2   read latency of pixel RAM in clk cycles (>=1)
//  START_DLY     4   cycles frame_sync is high before first read
//  BCM_W         16  width of bcm_base
// PORTS
//  clk             in   1        system clock
//  resetn          in   1        asynchronous active-low reset
//  enable          in   1        run frames continuously while high
//  pixels_per_row  in   X_W      pixels shifted per row (chain length * panel width)
//  bcm_base        in   BCM_W    on-time (clk cycles) of plane MIN_PLANE
//  blank_guard     in   8        cycles oe_n held high before row_addr change
//  swap_req        in   1        request front/back buffer swap at next frame end
//  swap_ack        out  1        1-cycle pulse: swap granted at frame boundary
//  frame_sync      out  1        high for START_DLY+1 cycles at frame start
//  frame_done      out  1        1-cycle pulse when last row's on-time ends
//  busy            out  1        high from frame start to frame_done
//  plane           out  3        current bit plane for RAM
//  rd_addr         out  ROW_W+X_W {row, x} RAM read address
//  rd_en           out  1        RAM read strobe
//  led_clk_en      out  1        rd_en delayed RAM_LAT cycles; drives DDR output clock
//  latch           out  1        1-cycle latch pulse
//  oe_n            out  1        LED output enable, active low
//  row_addr        out  ROW_W    ABCDE row select
// BEHAVIOUR
//  Reset: all outputs 0 except oe_n=1; plane=NUM_PLANES-1; state IDLE; on-timer 0.
//  States: IDLE->START->SHIFT->DRAIN->WAIT_OE->GUARD->LATCH->LIGHT->(SHIFT | NEXT_PLANE->SHIFT | FRAME_END->IDLE).
//  IDLE: if enable && pixels_per_row!=0 && on-timer==0: capture pixels_per_row, bcm_base, blank_guard into
//   shadow regs (used for whole frame), frame_sync=1, busy=1, ->START. pixels_per_row==0 keeps IDLE.
//  START: START_DLY cycles, then frame_sync=0, plane=NUM_PLANES-1, row=0, x=0.
//  SHIFT: rd_en=1 for exactly pixels_per_row consecutive cycles, x 0..ppr-1; led_clk_en mirrors rd_en RAM_LAT later.
//  DRAIN: RAM_LAT cycles for led_clk_en to finish. Shifting overlaps the previous row's on-time.
//  WAIT_OE: hold until on-timer==0 (oe_n=1). GUARD: blank_guard cycles (0 = skip), then row_addr<=row.
//  LATCH: latch=1 one cycle. LIGHT: load on-timer = bcm_base << (plane-MIN_PLANE); oe_n=0 from next cycle for
//   exactly that many cycles. Timer width BCM_W+NUM_PLANES-MIN_PLANE-1, no overflow. bcm_base==0: oe_n stays 1.
//  After LIGHT: row<NUM_ROWS-1 -> row+1, SHIFT; else plane>MIN_PLANE -> plane-1, row 0, SHIFT; else FRAME_END.
//  FRAME_END: wait on-timer==0, pulse frame_done, busy=0; if swap_req high that cycle, swap_ack pulses same cycle.
//  Next frame starts no earlier than the cycle after frame_done. enable low mid-frame: frame completes, then IDLE.
//  Config inputs changing mid-frame: no effect until next frame. Async reset mid-frame: immediate reset values, oe_n=1.
// TESTING
//  ppr=4, NUM_ROWS=2, planes 7..2, base=10, guard=0: oe_n low 320,160,80,40,20,10 cycles per row; 12 latches/frame.
//  RAM_LAT=2: rd_en high 4 cycles, led_clk_en high 4 cycles starting 2 cycles later; rd_addr x=0,1,2,3.
//  guard=5: >=5 cycles between oe_n rise and row_addr change; latch exactly 1 cycle after row_addr update.
//  swap_req held from mid-frame: swap_ack single pulse coincident with frame_done; none while swap_req=0.
//  change bcm_base 10->20 mid-frame: current frame unchanged; next frame plane-2 on-time=20 cycles.
//  enable drop mid-frame then resetn low 3 cycles: frame aborted, oe_n=1, plane=7, busy=0, restarts on enable.

Source files
------------

// File: rtl/hub75_bcm_scan_gen.sv
// hub75_bcm_scan_gen: HUB75 row scan and binary-coded-modulation timing.
// The next row is read from pixel RAM and shifted out while the current row is lit.
module hub75_bcm_scan_gen #(
    parameter int NUM_ROWS   = 32,
    parameter int ROW_W      = 5,
    parameter int X_W        = 10,
    parameter int NUM_PLANES = 8,
    parameter int MIN_PLANE  = 2,
    parameter int RAM_LAT    = 2,
    parameter int START_DLY  = 4,
    parameter int BCM_W      = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [X_W-1:0]       pixels_per_row,
    input  logic [BCM_W-1:0]     bcm_base,
    input  logic [7:0]           blank_guard,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 frame_sync,
    output logic                 frame_done,
    output logic                 busy,
    output logic [2:0]           plane,
    output logic [ROW_W+X_W-1:0] rd_addr,
    output logic                 rd_en,
    output logic                 led_clk_en,
    output logic                 latch,
    output logic                 oe_n,
    output logic [ROW_W-1:0]     row_addr
);

    localparam int TMR_W = BCM_W + NUM_PLANES - MIN_PLANE - 1;
    localparam logic [2:0] PLANE_TOP = 3'(NUM_PLANES - 1);
    localparam logic [2:0] PLANE_BOT = 3'(MIN_PLANE);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [7:0] START_LAST = 8'(START_DLY - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(RAM_LAT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_DRAIN,
        S_WAIT_OE,
        S_GUARD,
        S_LATCH,
        S_LIGHT,
        S_NEXT_PLANE,
        S_FRAME_END
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [X_W-1:0]         ppr_q, ppr_d;
    logic [BCM_W-1:0]       base_q, base_d;
    logic [7:0]             guard_q, guard_d;
    logic [RAM_LAT-1:0]     lat_sr_q, lat_sr_d;
    logic                   swap_ack_q, swap_ack_d;
    logic                   frame_sync_q, frame_sync_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic [2:0]             plane_q, plane_d;
    logic [ROW_W+X_W-1:0]   rd_addr_q, rd_addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   latch_q, latch_d;
    logic                   oe_n_q, oe_n_d;
    logic [ROW_W-1:0]       row_addr_q, row_addr_d;

    // Next-state and next-output logic for the scan sequencer and on-timer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        row_d        = row_q;
        ppr_d        = ppr_q;
        base_d       = base_q;
        guard_d      = guard_q;
        frame_sync_d = frame_sync_q;
        busy_d       = busy_q;
        plane_d      = plane_q;
        rd_addr_d    = rd_addr_q;
        row_addr_d   = row_addr_q;
        swap_ack_d   = 1'b0;
        frame_done_d = 1'b0;
        rd_en_d      = 1'b0;
        latch_d      = 1'b0;
        lat_sr_d     = (lat_sr_q << 1) | RAM_LAT'(rd_en_q);
        tmr_d        = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable && pixels_per_row != '0 && tmr_q == '0) begin
                    ppr_d        = pixels_per_row;
                    base_d       = bcm_base;
                    guard_d      = blank_guard;
                    frame_sync_d = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (cnt_q == START_LAST) begin
                    plane_d = PLANE_TOP;
                    row_d   = '0;
                    x_d     = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                frame_sync_d = 1'b0;
                rd_en_d      = 1'b1;
                rd_addr_d    = {row_q, x_q};
                x_d          = x_q + 1'b1;
                if (x_q == ppr_q - 1'b1) begin
                    cnt_d   = 8'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_WAIT_OE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_OE: begin
                if (tmr_q == '0) begin
                    cnt_d = 8'd0;
                    if (guard_q == 8'd0) begin
                        row_addr_d = row_q;
                        state_d    = S_LATCH;
                    end else begin
                        state_d = S_GUARD;
                    end
                end
            end
            S_GUARD: begin
                if (cnt_q == guard_q - 8'd1) begin
                    row_addr_d = row_q;
                    state_d    = S_LATCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LATCH: begin
                latch_d = 1'b1;
                state_d = S_LIGHT;
            end
            S_LIGHT: begin
                tmr_d = TMR_W'(base_q) << (plane_q - PLANE_BOT);
                x_d   = '0;
                if (row_q != ROW_LAST) begin
                    row_d   = row_q + 1'b1;
                    state_d = S_SHIFT;
                end else if (plane_q > PLANE_BOT) begin
                    state_d = S_NEXT_PLANE;
                end else begin
                    state_d = S_FRAME_END;
                end
            end
            S_NEXT_PLANE: begin
                plane_d = plane_q - 3'd1;
                row_d   = '0;
                state_d = S_SHIFT;
            end
            S_FRAME_END: begin
                if (tmr_q == '0) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    swap_ack_d   = swap_req;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        oe_n_d = (tmr_d == '0);
    end

    // State, shadow config and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            x_q          <= '0;
            row_q        <= '0;
            tmr_q        <= '0;
            ppr_q        <= '0;
            base_q       <= '0;
            guard_q      <= 8'd0;
            lat_sr_q     <= '0;
            swap_ack_q   <= 1'b0;
            frame_sync_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            plane_q      <= PLANE_TOP;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            row_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            row_q        <= row_d;
            tmr_q        <= tmr_d;
            ppr_q        <= ppr_d;
            base_q       <= base_d;
            guard_q      <= guard_d;
            lat_sr_q     <= lat_sr_d;
            swap_ack_q   <= swap_ack_d;
            frame_sync_q <= frame_sync_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            plane_q      <= plane_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            latch_q      <= latch_d;
            oe_n_q       <= oe_n_d;
            row_addr_q   <= row_addr_d;
        end
    end

    assign swap_ack   = swap_ack_q;
    assign frame_sync = frame_sync_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign plane      = plane_q;
    assign rd_addr    = rd_addr_q;
    assign rd_en      = rd_en_q;
    assign led_clk_en = lat_sr_q[RAM_LAT-1];
    assign latch      = latch_q;
    assign oe_n       = oe_n_q;
    assign row_addr   = row_addr_q;

endmodule
